mod_reg16_ser: RTL and testbench
================================

# mod_reg16_ser

Byte-serialising source that drives the byte-wide S-box feed FIFO ahead of the substitution ROM. It loads one 128-bit AES state word and presents it one byte at a time on `outp`, with `empty` as the "no byte available" flag. A byte is consumed on every clock edge where the downstream single-entry FIFO captures it, i.e. when `fifo_empty` is high and `empty` is low. It signals `ready` and pulses `done` when all 16 bytes have been taken.

## Interface
- `NBYTES`, 16, bytes per state word; the ports below assume 16 (the data width is 8·NBYTES).
- `clk`  in  1  single clock; all state updates on posedge.
- `resetn`  in  1  synchronous, active-low reset, sampled on posedge `clk`.
- `load`  in  1  load request for `data_in`; honoured only while `ready`=1.
- `data_in`  in  128  state word; byte 0 is `data_in[127:120]` and is sent first.
- `fifo_empty`  in  1  downstream FIFO empty flag; high means the FIFO captures `outp` this edge if `empty`=0.
- `outp`  out  8  current byte, registered; connects to the FIFO byte input.
- `empty`  out  1  high when no byte is pending; connects to the FIFO `reg16_empty` input.
- `ready`  out  1  high in IDLE; the block can accept `load`.
- `done`  out  1  one-cycle pulse after the last byte is consumed.

## Operation
- Two states:
  - IDLE: `ready`=1, `empty`=1.
  - SEND: `ready`=0, `empty`=0.
- Internal registers:
  - 128-bit shift register `sh`.
  - 5-bit byte counter `cnt`, range 0..16.
- Output mapping: `outp` = `sh[127:120]` at all times. It is a register bit, not a mux of `data_in`.
- Load:
  - IDLE and `load`=1 at an edge: `sh`<=`data_in`, `cnt`<=0, go to SEND.
  - `load` in SEND is ignored; `sh` is unchanged.
- Transfer condition: `xfer` = SEND & `fifo_empty` & ~`empty`.
- On `xfer`:
  - `sh`<=`{sh[119:0],8'h00}`.
  - `cnt`<=`cnt`+1.
- Last byte: `xfer` with `cnt`=15 goes to IDLE, sets `empty`<=1, `ready`<=1, `done`<=1 for one cycle. `sh` becomes all zero, so `outp` reads 00.
- `fifo_empty`=0 in SEND: hold `sh`, `cnt`, `outp`, `empty` unchanged. There is no timeout.
- `done` is high only for the cycle after the last transfer. Otherwise it is 0.
- `cnt` never exceeds 16. It does not wrap; a new load resets it to 0.
- Reset has priority over everything:
  - `sh`=0, `cnt`=0, state IDLE.
  - `outp`=8'h00, `empty`=1, `ready`=1, `done`=0.
- Reset asserted mid-SEND aborts the word: bytes not yet sent are discarded and `done` does not pulse.
- `load` sampled in the same edge as an active reset is ignored.

## Timing
- Edge N: `load` accepted. From cycle N+1, `outp`=byte 0, `empty`=0, `ready`=0.
- The FIFO captures byte k at the first edge where `fifo_empty`=1 in SEND. `outp` shows byte k+1 from the following cycle.
- Peak throughput is one byte per cycle, when `fifo_empty` is held high. A full word then takes 16 cycles after the load cycle.
- With the single-entry FIFO draining every other cycle, one byte is sent per two cycles.
- Last transfer at edge M: `done`=1, `ready`=1, `empty`=1 during cycle M+1. The earliest new `load` is accepted at edge M+1.
- No combinational path from any input to any output.

## Test plan
- Reset: hold `resetn`=0 for 2 cycles with random inputs. Expect `outp`=00, `empty`=1, `ready`=1, `done`=0, and `load` ignored.
- Streaming: load 0x00112233445566778899AABBCCDDEEFF with `fifo_empty`=1 held.
  - `outp` sequence is 00,11,…,FF on 16 consecutive edges.
  - `done` is high exactly in cycle load+17.
  - `empty` is high from the same cycle.
- Backpressure: same word, with `fifo_empty` pulsed high once every 3 cycles.
  - `outp` and `empty` hold between pulses.
  - Exactly 16 bytes in order, `done` one cycle after the 16th pulse.
- Busy load: in SEND after 5 bytes, assert `load` with 0xFFFF…FF. Expect it ignored: the remaining bytes are 55…FF and `ready` stays 0.
- Reset mid-word: assert reset after byte 7. Expect IDLE, `empty`=1, no `done`. A new load restarts at byte 0 of the new word.
- Back-to-back words: assert `load` at the first `ready` cycle after `done`. Expect a one-cycle `empty` gap between words and correct ordering for both.

Source files
------------

// File: rtl/mod_reg16_ser_if.sv
// Byte-serialiser bus: word load on one side, byte feed to the S-box FIFO on the other.
interface mod_reg16_ser_if #(
    parameter int NBYTES = 16
);
    logic                  load;
    logic [8*NBYTES-1:0]   data_in;
    logic                  fifo_empty;
    logic [7:0]            outp;
    logic                  empty;
    logic                  ready;
    logic                  done;

    modport master (
        output load, data_in, fifo_empty,
        input  outp, empty, ready, done
    );

    modport slave (
        input  load, data_in, fifo_empty,
        output outp, empty, ready, done
    );
endinterface

// File: rtl/mod_reg16_ser.sv
// Loads one AES state word and feeds it MSB-byte first into the single-entry S-box FIFO.
module mod_reg16_ser #(
    parameter int NBYTES = 16
) (
    input  logic           clk,
    input  logic           resetn,
    mod_reg16_ser_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    sh, sh_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            done_r, done_nxt;
    logic            xfer;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            sh     <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            sh     <= sh_nxt;
            cnt    <= cnt_nxt;
            done_r <= done_nxt;
        end
    end

    // empty is low exactly in SEND, so the FIFO capture reduces to SEND & fifo_empty
    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        xfer      = (state == SEND) && bus.fifo_empty;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    sh_nxt    = bus.data_in;
                    cnt_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    sh_nxt  = {sh[W-9:0], 8'h00};
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CW'(NBYTES - 1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.outp  = sh[W-1 -: 8];
    assign bus.empty = (state == IDLE);
    assign bus.ready = (state == IDLE);
    assign bus.done  = done_r;
endmodule

// File: tb/tb_mod_reg16_ser.sv
// Directed bench for the 16-byte serialiser: reset, streaming, backpressure, busy load, abort, back-to-back.
module tb_mod_reg16_ser;
    logic clk = 1'b0;
    logic resetn;
    int   n_chk  = 0;
    int   n_fail = 0;

    localparam logic [127:0] W1 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] W2 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

    mod_reg16_ser_if #(.NBYTES(16)) bus ();

    mod_reg16_ser #(.NBYTES(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] w, input int k);
        return w[127 - 8*k -: 8];
    endfunction

    // Issue a load now; returns in the first cycle after the accepting edge.
    task automatic do_load(input logic [127:0] w);
        bus.load    = 1'b1;
        bus.data_in = w;
        tick();
        bus.load    = 1'b0;
    endtask

    // Stream bytes first..15 with fifo_empty held high, ending in the done cycle.
    task automatic stream(input string tag, input logic [127:0] w, input int first);
        bus.fifo_empty = 1'b1;
        for (int k = first; k < 16; k++) begin
            chk({tag, "_outp"}, {24'h0, bus.outp}, {24'h0, byte_of(w, k)});
            chk({tag, "_empty"}, {31'h0, bus.empty}, 32'h0);
            chk({tag, "_done_low"}, {31'h0, bus.done}, 32'h0);
            tick();
        end
    endtask

    task automatic chk_done_cycle(input string tag);
        chk({tag, "_done"}, {31'h0, bus.done}, 32'h1);
        chk({tag, "_empty_end"}, {31'h0, bus.empty}, 32'h1);
        chk({tag, "_ready_end"}, {31'h0, bus.ready}, 32'h1);
        chk({tag, "_outp_end"}, {24'h0, bus.outp}, 32'h0);
    endtask

    initial begin
        // reset with junk on the inputs, including a load request
        resetn         = 1'b0;
        bus.load       = 1'b1;
        bus.data_in    = {$urandom, $urandom, $urandom, $urandom};
        bus.fifo_empty = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_outp", {24'h0, bus.outp}, 32'h0);
            chk("rst_empty", {31'h0, bus.empty}, 32'h1);
            chk("rst_ready", {31'h0, bus.ready}, 32'h1);
            chk("rst_done", {31'h0, bus.done}, 32'h0);
        end
        bus.load   = 1'b0;
        resetn     = 1'b1;
        tick();
        chk("rst_load_ignored", {31'h0, bus.ready}, 32'h1);
        chk("rst_outp_after", {24'h0, bus.outp}, 32'h0);

        // streaming at one byte per cycle
        bus.fifo_empty = 1'b1;
        do_load(W1);
        chk("str_ready_low", {31'h0, bus.ready}, 32'h0);
        stream("str", W1, 0);
        chk_done_cycle("str");
        tick();
        chk("str_done_pulse", {31'h0, bus.done}, 32'h0);

        // backpressure: FIFO drains once every third cycle
        bus.fifo_empty = 1'b0;
        do_load(W1);
        for (int k = 0; k < 16; k++) begin
            for (int h = 0; h < 2; h++) begin
                chk("bp_hold_outp", {24'h0, bus.outp}, {24'h0, byte_of(W1, k)});
                chk("bp_hold_empty", {31'h0, bus.empty}, 32'h0);
                chk("bp_hold_done", {31'h0, bus.done}, 32'h0);
                tick();
            end
            bus.fifo_empty = 1'b1;
            chk("bp_pulse_outp", {24'h0, bus.outp}, {24'h0, byte_of(W1, k)});
            tick();
            bus.fifo_empty = 1'b0;
        end
        chk_done_cycle("bp");
        tick();
        chk("bp_done_pulse", {31'h0, bus.done}, 32'h0);

        // load while busy must be ignored
        bus.fifo_empty = 1'b1;
        do_load(W1);
        for (int k = 0; k < 5; k++) begin
            chk("busy_pre_outp", {24'h0, bus.outp}, {24'h0, byte_of(W1, k)});
            tick();
        end
        bus.load    = 1'b1;
        bus.data_in = {128{1'b1}};
        for (int k = 5; k < 16; k++) begin
            chk("busy_outp", {24'h0, bus.outp}, {24'h0, byte_of(W1, k)});
            chk("busy_ready", {31'h0, bus.ready}, 32'h0);
            tick();
        end
        bus.load = 1'b0;
        chk_done_cycle("busy");
        tick();

        // reset after byte 7 aborts the word
        do_load(W1);
        for (int k = 0; k < 8; k++) tick();
        chk("abort_pre_outp", {24'h0, bus.outp}, 32'h88);
        resetn = 1'b0;
        tick();
        chk("abort_empty", {31'h0, bus.empty}, 32'h1);
        chk("abort_ready", {31'h0, bus.ready}, 32'h1);
        chk("abort_outp", {24'h0, bus.outp}, 32'h0);
        chk("abort_done", {31'h0, bus.done}, 32'h0);
        resetn = 1'b1;
        tick();
        chk("abort_done2", {31'h0, bus.done}, 32'h0);
        chk("abort_idle", {31'h0, bus.ready}, 32'h1);
        do_load(W2);
        chk("abort_restart", {24'h0, bus.outp}, 32'h0F);
        stream("restart", W2, 0);
        chk_done_cycle("restart");
        tick();

        // back-to-back words with the earliest possible second load
        do_load(W1);
        stream("b2b1", W1, 0);
        chk_done_cycle("b2b1");
        bus.load    = 1'b1;
        bus.data_in = W2;
        tick();
        bus.load = 1'b0;
        chk("b2b_ready", {31'h0, bus.ready}, 32'h0);
        chk("b2b_done_clear", {31'h0, bus.done}, 32'h0);
        stream("b2b2", W2, 0);
        chk_done_cycle("b2b2");
        tick();
        chk("b2b_final_done", {31'h0, bus.done}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
